// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and the
// sizing helper for the shared stabilize/hold down-counter.
package pll_reset_pkg;

  typedef logic [1:0] state_t;

  localparam state_t WAIT_LOCK = 2'd0;
  localparam state_t STABILIZE = 2'd1;
  localparam state_t HOLD      = 2'd2;
  localparam state_t RUN       = 2'd3;

  // Width needed to hold the larger of the two load values.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for bringing an asynchronous level into
// the local clock domain. Both flops clear synchronously on reset.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q may be used by downstream logic.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock pin into a clean synchronous system reset
// and a ready flag. Lock must be stable for LOCK_STABLE_CYCLES, then reset is
// held another RESET_HOLD_CYCLES before release. Any lock drop restarts the
// sequence; drops while running are flagged and counted for debug.
// Optional LED heartbeat is built when PLL_RST_HEARTBEAT_EN is defined;
// otherwise the heartbeat port is tied low.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int LOSS_CNT_W         = 8,
  parameter int HEARTBEAT_LOG2     = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  locked,
  output logic                  sys_reset,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic                  heartbeat
);

  localparam int CW = cnt_w(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
  localparam logic [CW-1:0] STAB_LOAD = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RESET_HOLD_CYCLES - 1);

  logic          locked_s;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          loss_evt;

  sync_2ff u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked),
    .q     (locked_s)
  );

  // State and shared down-counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: counter is reloaded on every state entry, decremented otherwise.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_evt  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABILIZE;
          cnt_nxt   = STAB_LOAD;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          loss_evt  = 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Moore outputs straight from the state register; no path from locked.
  always_comb begin
    sys_reset = (state != RUN);
    ready     = (state == RUN);
  end

  // Sticky loss flag and saturating loss counter; cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else if (loss_evt) begin
      lock_lost <= 1'b1;
      if (!(&loss_count)) loss_count <= loss_count + 1'b1;
    end
  end

`ifdef PLL_RST_HEARTBEAT_EN
  logic [HEARTBEAT_LOG2-1:0] hb_cnt;

  // Free-running only while ready, parked at zero otherwise.
  always_ff @(posedge clock) begin
    if (reset || !ready) hb_cnt <= '0;
    else                 hb_cnt <= hb_cnt + 1'b1;
  end

  assign heartbeat = hb_cnt[HEARTBEAT_LOG2-1];
`else
  assign heartbeat = 1'b0;
`endif

endmodule
